// File: rtl/switch_press_classifier.sv
// Classifies debounced switch presses as short or long, with optional auto-repeat
// while held (enabled by defining AUTO_REPEAT_EN), and keeps a 4-bit event tally.
module switch_press_classifier #(
  parameter int unsigned c_LONG_LIMIT   = 25000000,
  parameter int unsigned c_REPEAT_LIMIT = 5000000,
  parameter int unsigned c_CNT_WIDTH    = 25
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  output logic       o_Short_Pulse,
  output logic       o_Long_Pulse,
  output logic       o_Repeat_Pulse,
  output logic       o_Active,
  output logic [3:0] o_Count
);

  localparam int unsigned c_TALLY_WIDTH = 4;
  localparam int unsigned c_MAX_LIMIT   =
    (c_LONG_LIMIT > c_REPEAT_LIMIT) ? c_LONG_LIMIT : c_REPEAT_LIMIT;
  localparam logic [c_CNT_WIDTH-1:0] c_LONG_LAST = c_CNT_WIDTH'(c_LONG_LIMIT - 1);

  // Elaboration-time guard on the limits and the counter width
  if (c_LONG_LIMIT < 2 || c_REPEAT_LIMIT < 2 ||
      ((c_MAX_LIMIT - 1) >> c_CNT_WIDTH) != 0) begin : g_param_check
    $error("switch_press_classifier: invalid limit or counter width parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [c_CNT_WIDTH-1:0] cnt;
  logic [c_CNT_WIDTH-1:0] cnt_next;
  logic                   short_next;
  logic                   long_next;
  logic                   event_next;

`ifdef AUTO_REPEAT_EN
  localparam logic [c_CNT_WIDTH-1:0] c_REPEAT_LAST = c_CNT_WIDTH'(c_REPEAT_LIMIT - 1);
  logic repeat_next;
`endif

  // State and cycle counter
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and pulse decisions; release takes priority over a limit hit
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    short_next = 1'b0;
    long_next  = 1'b0;
`ifdef AUTO_REPEAT_EN
    repeat_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (i_Switch) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end
      end
      PRESSED: begin
        if (!i_Switch) begin
          state_next = IDLE;
          cnt_next   = '0;
          short_next = 1'b1;
        end else if (cnt == c_LONG_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt + c_CNT_WIDTH'(1);
        end
      end
      HELD: begin
        if (!i_Switch) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt == c_REPEAT_LAST) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt + c_CNT_WIDTH'(1);
        end
`endif
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  assign event_next = short_next | long_next | repeat_next;
`else
  assign event_next = short_next | long_next;
`endif

  // Registered pulses, activity flag and wrapping tally
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Short_Pulse <= 1'b0;
      o_Long_Pulse  <= 1'b0;
      o_Active      <= 1'b0;
      o_Count       <= '0;
    end else begin
      o_Short_Pulse <= short_next;
      o_Long_Pulse  <= long_next;
      o_Active      <= (state_next != IDLE);
      o_Count       <= o_Count + c_TALLY_WIDTH'(event_next);
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Repeat_Pulse <= 1'b0;
    end else begin
      o_Repeat_Pulse <= repeat_next;
    end
  end
`else
  assign o_Repeat_Pulse = 1'b0;
`endif

endmodule
